// File: rtl/store_narrow_unit.sv
// Byte-serial store path: truncates a register value to word/half/byte and
// writes it little-endian to an 8-bit memory port with ack/timeout handling.
module store_narrow_unit #(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        st_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic              tmo_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = (WAIT_MAX > 0) ? WW'(WAIT_MAX - 1) : '0;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_last;
  logic [1:0]        r_k;
  logic [WW-1:0]     r_wait;
  logic              r_addr_err;
  logic              r_tmo_err;

  logic       w_bad;
  logic [1:0] w_last;
  logic       w_timeout;
  logic [7:0] w_byte;
  logic       w_write;

  // Alignment check and last byte index for the incoming request.
  always_comb begin
    w_bad  = 1'b0;
    w_last = 2'd0;
    case (st_op)
      2'b00: begin
        w_bad  = (addr[1:0] != 2'b00);
        w_last = 2'd3;
      end
      2'b01: begin
        w_bad  = addr[0];
        w_last = 2'd1;
      end
      2'b10: begin
        w_bad  = 1'b0;
        w_last = 2'd0;
      end
      default: begin
        w_bad  = 1'b1;
        w_last = 2'd0;
      end
    endcase
  end

  // An ack in the final wait cycle wins over the timeout.
  assign w_timeout = (WAIT_MAX != 0) && (r_wait == WAIT_LAST) && !mem_ack;

  always_comb begin
    w_byte = 8'd0;
    case (r_k)
      2'd0:    w_byte = r_data[7:0];
      2'd1:    w_byte = r_data[15:8];
      2'd2:    w_byte = r_data[23:16];
      default: w_byte = r_data[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_last     <= 2'd0;
      r_k        <= 2'd0;
      r_wait     <= '0;
      r_addr_err <= 1'b0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      r_tmo_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_bad) begin
              r_addr_err <= 1'b1;
            end else begin
              r_addr  <= addr;
              r_data  <= wdata;
              r_last  <= w_last;
              r_k     <= 2'd0;
              r_wait  <= '0;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_wait <= '0;
            if (r_k == r_last) begin
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end else if (w_timeout) begin
            r_state   <= S_IDLE;
            r_tmo_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_write   = (r_state == S_WRITE);
  assign mem_we    = w_write;
  assign mem_addr  = w_write ? (r_addr + ADDR_W'(r_k)) : '0;
  assign mem_wdata = w_write ? w_byte : 8'd0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign addr_err  = r_addr_err;
  assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: directed stores push expected
// memory writes and pulses; a negedge monitor pops and compares them.
module tb_store_narrow_unit;

  localparam int KIND_WR   = 0;
  localparam int KIND_DONE = 1;
  localparam int KIND_AERR = 2;
  localparam int KIND_TMO  = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [7:0]  d;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  st_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        addr_err;
  logic        tmo_err;

  int   checks;
  int   failures;
  int   ackMode;
  int   ackWait;
  exp_t sbQ[$];

  store_narrow_unit #(.ADDR_W(32), .WAIT_MAX(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .st_op     (st_op),
    .addr      (addr),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .addr_err  (addr_err),
    .tmo_err   (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pushWrite(input logic [31:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = KIND_WR;
    e.a    = a;
    e.d    = d;
    sbQ.push_back(e);
  endtask

  task automatic pushEvent(input int kind);
    exp_t e;
    e.kind = kind;
    e.a    = '0;
    e.d    = '0;
    sbQ.push_back(e);
  endtask

  // An aborted store leaves its unacked byte at the head; the timeout drops it.
  task automatic checkEvent(input int kind, input string name);
    if (kind == KIND_TMO && sbQ.size() > 0 && sbQ[0].kind == KIND_WR)
      void'(sbQ.pop_front());
    checks++;
    if (sbQ.size() == 0 || sbQ[0].kind != kind) begin
      failures++;
      $display("[TB] FAIL %s actual=pulse expected=%0s", name,
               (sbQ.size() == 0) ? "nothing" : "other_event");
    end else begin
      void'(sbQ.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (sbQ.size() == 0 || sbQ[0].kind != KIND_WR) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_we actual=%0h:%0h expected=no_write", mem_addr, mem_wdata);
        end else begin
          checkOutput("mem_addr", mem_addr, sbQ[0].a);
          checkOutput("mem_wdata", {24'd0, mem_wdata}, {24'd0, sbQ[0].d});
          if (mem_ack) void'(sbQ.pop_front());
        end
      end
      if (done)     checkEvent(KIND_DONE, "done_pulse");
      if (addr_err) checkEvent(KIND_AERR, "addr_err_pulse");
      if (tmo_err)  checkEvent(KIND_TMO, "tmo_err_pulse");
    end
  end

  // Memory ack model: 0 tied high, 1 three-cycle stall per byte, 2 never, 3 ack on 15th cycle.
  always @(posedge clk) begin
    #1;
    if (ackMode == 0) begin
      mem_ack = 1'b1;
      ackWait = 0;
    end else if (!mem_we) begin
      mem_ack = 1'b0;
      ackWait = 0;
    end else begin
      case (ackMode)
        1:       mem_ack = (ackWait == 3);
        3:       mem_ack = (ackWait == 14);
        default: mem_ack = 1'b0;
      endcase
      ackWait = mem_ack ? 0 : ackWait + 1;
    end
  end

  task automatic syncEdge();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one rising edge; caller is just past an edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    st_op     = op;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic measure(input string name, output int busyCnt, output int weCnt);
    bit finished;
    busyCnt  = 0;
    weCnt    = 0;
    finished = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_we) weCnt++;
      if (busy) busyCnt++;
      else begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_idle actual=busy expected=idle_within_100", name);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bc;
    int wc;
    checks    = 0;
    failures  = 0;
    ackMode   = 0;
    ackWait   = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    st_op     = 2'b00;
    addr      = '0;
    wdata     = '0;
    mem_ack   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_pulses", {29'd0, done, addr_err, tmo_err}, 32'd0);
    syncEdge();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Word store with ack tied high.
    syncEdge();
    pushWrite(32'h100, 8'hD4);
    pushWrite(32'h101, 8'hC3);
    pushWrite(32'h102, 8'hB2);
    pushWrite(32'h103, 8'hA1);
    pushEvent(KIND_DONE);
    applyStimulus(2'b00, 32'h100, 32'hA1B2C3D4);
    checkOutput("sw_ready_low", {31'd0, req_ready}, 32'd0);
    measure("sw", bc, wc);
    checkOutput("sw_busy_cycles", bc, 5);
    checkOutput("sw_we_cycles", wc, 4);

    // Half and byte truncation.
    syncEdge();
    pushWrite(32'h202, 8'h01);
    pushWrite(32'h203, 8'h80);
    pushEvent(KIND_DONE);
    applyStimulus(2'b01, 32'h202, 32'hFFFF8001);
    measure("sh", bc, wc);
    checkOutput("sh_we_cycles", wc, 2);
    syncEdge();
    pushWrite(32'h307, 8'h78);
    pushEvent(KIND_DONE);
    applyStimulus(2'b10, 32'h307, 32'h12345678);
    measure("sb", bc, wc);
    checkOutput("sb_busy_cycles", bc, 2);

    // Misaligned and reserved requests back to back, then a valid byte store.
    syncEdge();
    pushEvent(KIND_AERR);
    applyStimulus(2'b01, 32'h201, 32'h0000BEEF);
    checkOutput("aerr_level", {31'd0, addr_err}, 32'd1);
    checkOutput("aerr_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("aerr_no_we", {31'd0, mem_we}, 32'd0);
    pushEvent(KIND_AERR);
    applyStimulus(2'b00, 32'h102, 32'h11111111);
    pushEvent(KIND_AERR);
    applyStimulus(2'b11, 32'h100, 32'h22222222);
    pushWrite(32'h400, 8'hAB);
    pushEvent(KIND_DONE);
    applyStimulus(2'b10, 32'h400, 32'h000000AB);
    measure("aerr_sb", bc, wc);
    checkOutput("aerr_sb_we_cycles", wc, 1);

    // Three stall cycles before every byte.
    ackMode = 1;
    syncEdge();
    pushWrite(32'h800, 8'h44);
    pushWrite(32'h801, 8'h33);
    pushWrite(32'h802, 8'h22);
    pushWrite(32'h803, 8'h11);
    pushEvent(KIND_DONE);
    applyStimulus(2'b00, 32'h800, 32'h11223344);
    measure("stall", bc, wc);
    checkOutput("stall_we_cycles", wc, 16);
    checkOutput("stall_busy_cycles", bc, 17);

    // No ack at all: abort after 15 write cycles.
    ackMode = 2;
    syncEdge();
    pushWrite(32'h600, 8'hEF);
    pushEvent(KIND_TMO);
    applyStimulus(2'b00, 32'h600, 32'hDEADBEEF);
    measure("tmo", bc, wc);
    checkOutput("tmo_we_cycles", wc, 15);
    checkOutput("tmo_busy_cycles", bc, 15);

    // Ack arrives on the 15th write cycle and beats the timeout.
    ackMode = 3;
    syncEdge();
    pushWrite(32'h701, 8'h5A);
    pushEvent(KIND_DONE);
    applyStimulus(2'b10, 32'h701, 32'h0000005A);
    measure("late_ack", bc, wc);
    checkOutput("late_ack_we_cycles", wc, 15);
    checkOutput("late_ack_busy_cycles", bc, 16);

    // Reset during the second byte of a word store.
    ackMode = 0;
    syncEdge();
    pushWrite(32'h500, 8'h11);
    applyStimulus(2'b00, 32'h500, 32'h44332211);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    syncEdge();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", sbQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the immediate/load extender: takes a 32-bit register value and a store width (word/half/byte), truncates it, and writes it byte-serially to an 8-bit data-memory port.
- Sits between the datapath's store stage and a byte-wide memory.
- Uses a valid/ready request handshake toward the CPU and a we/ack handshake toward memory.
- Reports completion, misalignment and memory-timeout events as one-cycle pulses.

Parameters:
- ADDR_W, 32, width of byte address.
- WAIT_MAX, 15, max cycles a byte write may wait for mem_ack before abort; 0 = wait forever.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- st_op  input  2  store width: 2'b00 word (sw), 2'b01 half (sh), 2'b10 byte (sb), 2'b11 reserved.
- addr  input  ADDR_W  byte address of store.
- wdata  input  32  register value to store (rt).
- mem_addr  output  ADDR_W  byte address of current memory write.
- mem_wdata  output  8  byte being written.
- mem_we  output  1  memory write strobe, held until acked.
- mem_ack  input  1  memory accepted current byte.
- busy  output  1  high from accept until return to IDLE.
- done  output  1  one-cycle pulse: all bytes written.
- addr_err  output  1  one-cycle pulse: misaligned or reserved op, nothing written.
- tmo_err  output  1  one-cycle pulse: mem_ack timeout, store aborted.

Behaviour:
- Reset (async, rst_n=0), effective immediately and mid-operation:
  - state=IDLE; counters cleared.
  - mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, addr_err=0, tmo_err=0, req_ready=1 once rst_n=1.
  - A partially written store is abandoned, with no done and no err pulse.
- Accept occurs on a rising edge with req_valid & req_ready; addr, wdata and st_op are latched. Inputs are ignored outside IDLE.
- Alignment check at accept:
  - Word requires addr[1:0]==0; half requires addr[0]==0; byte is always aligned.
  - Reserved op or misalignment → addr_err=1 for the next cycle only. State stays IDLE, req_ready stays 1, and no mem_we is issued.
  - A new request may be accepted in that same error cycle.
- Byte count N = 4 (word), 2 (half), 1 (byte). Value truncated to low 8·N bits. Little-endian: byte k = wdata_lat[8k+7:8k], mem_addr = addr_lat + k, k=0..N-1.
- States:
  - IDLE: req_ready=1. Valid aligned accept → WRITE with k=0.
  - WRITE: mem_we=1 with mem_addr/mem_wdata stable.
    - On mem_ack at a rising edge: if k==N-1 → DONE, else k++ and stay in WRITE.
    - mem_we remains 1 between consecutive bytes, so back-to-back acks write one byte per cycle.
    - Latency for an N-byte store with ack asserted constantly: accept edge + N cycles of mem_we, then the done cycle.
  - DONE: done=1 for one cycle, mem_we=0, busy=1 → IDLE. req_ready=0 in DONE.
  - Timeout (WAIT_MAX>0): a wait counter resets on every byte start and ack. If WAIT_MAX consecutive WRITE cycles pass without mem_ack, go to IDLE with tmo_err=1 for one cycle and mem_we=0. Bytes already acked stay written.
- busy=1 in WRITE and DONE; 0 in IDLE.
- mem_ack outside WRITE is ignored. mem_ack in the same cycle the timeout fires is treated as a normal ack, which takes precedence over the timeout.
- mem_addr adds with wrap-around modulo 2^ADDR_W. For aligned stores this never crosses a word.

Test Plan:
- Reset values: hold rst_n=0 → all outputs 0 except req_ready=0→1 after release. Then assert rst_n=0 during byte 2 of a word store → mem_we drops asynchronously, no done pulse, unit back in IDLE.
- Word store: st_op=00, addr=0x100, wdata=0xA1B2C3D4, mem_ack tied 1 → writes (0x100,D4),(0x101,C3),(0x102,B2),(0x103,A1) on 4 consecutive cycles, then done pulse; busy high 5 cycles.
- Half and byte truncation: st_op=01, addr=0x202, wdata=0xFFFF8001 → writes (0x202,01),(0x203,80) only. Then st_op=10, addr=0x307, wdata=0x12345678 → a single write (0x307,78).
- Misalignment/reserved: sh addr=0x201 → addr_err pulse, no mem_we. sw addr=0x102 → addr_err. st_op=11 → addr_err. A valid sb issued the next cycle is accepted normally.
- Ack stall: word store with mem_ack low for 3 cycles before each byte → mem_addr/mem_wdata stable while waiting, 4 bytes in order, done after the last ack.
- Timeout: WAIT_MAX=15, mem_ack never asserted → tmo_err pulses after 15 WRITE cycles and the unit returns to IDLE. A variant with mem_ack on exactly cycle 15 → the byte is accepted and no tmo_err occurs.
